mbinit_substep_sequencer: RTL and testbench

//  Top-level MBINIT sequencer. Enables the MBINIT sub-step modules one at a time, in order:

---
 rtl/mbinit_substep_sequencer_if.sv | 31 +++
 rtl/mbinit_substep_sequencer.sv | 131 +++++++++++++
 tb/tb_mbinit_substep_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mbinit_substep_sequencer_if.sv
// Bundle between the MBINIT sequencer and its sub-step modules / LTSM.
// slave = sequencer side, master = environment driving the sub-step levels.
interface mbinit_substep_sequencer_if #(
    parameter int N_STEPS = 6,
    parameter int MSG_W   = 4
);
    logic                       i_MBINIT_en;
    logic [N_STEPS-1:0]         i_substep_end;
    logic [N_STEPS-1:0]         i_substep_error;
    logic [N_STEPS-1:0]         i_substep_sb_valid;
    logic [N_STEPS*MSG_W-1:0]   i_substep_sb_msg;
    logic [N_STEPS-1:0]         o_substep_start_en;
    logic [MSG_W-1:0]           o_TX_SbMessage;
    logic                       o_ValidOutDatat;
    logic [2:0]                 o_active_step;
    logic                       o_MBINIT_end;
    logic                       o_train_error_req;
    logic                       o_timeout;

    modport master (
        output i_MBINIT_en, i_substep_end, i_substep_error, i_substep_sb_valid, i_substep_sb_msg,
        input  o_substep_start_en, o_TX_SbMessage, o_ValidOutDatat, o_active_step,
               o_MBINIT_end, o_train_error_req, o_timeout
    );

    modport slave (
        input  i_MBINIT_en, i_substep_end, i_substep_error, i_substep_sb_valid, i_substep_sb_msg,
        output o_substep_start_en, o_TX_SbMessage, o_ValidOutDatat, o_active_step,
               o_MBINIT_end, o_train_error_req, o_timeout
    );
endinterface

// File: rtl/mbinit_substep_sequencer.sv
// MBINIT sequencer: walks PARAM..REPAIRMB one step at a time and muxes the active step's sideband TX.
// Optional per-step timeout enabled by defining MBINIT_TIMEOUT_EN.
module mbinit_substep_sequencer #(
    parameter int N_STEPS        = 6,
    parameter int MSG_W          = 4,
    parameter int TIMEOUT_CYCLES = 800000
) (
    input  logic                         CLK,
    input  logic                         rst,
    mbinit_substep_sequencer_if.slave    bus
);
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        HANDOFF,
        DONE,
        ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               timeout_d;
    logic               sb_valid_d;
    logic [MSG_W-1:0]   sb_msg_d;

    // The timeout counter is 20 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << 20)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range for a 20-bit counter");
    end

`ifdef MBINIT_TIMEOUT_EN
    logic [19:0] cnt_q, cnt_d;

    always_ff @(posedge CLK) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timeout_d = 1'b0;
`ifdef MBINIT_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        if (!bus.i_MBINIT_en) begin
            state_d = IDLE;
            idx_d   = '0;
`ifdef MBINIT_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACTIVE;
                    idx_d   = '0;
`ifdef MBINIT_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
                ACTIVE: begin
                    // Error beats end; end/error beat the timeout.
                    if (bus.i_substep_error[idx_q]) begin
                        state_d = ERROR;
                    end else if (bus.i_substep_end[idx_q]) begin
                        state_d = (idx_q == IDX_W'(N_STEPS - 1)) ? DONE : HANDOFF;
                    end
`ifdef MBINIT_TIMEOUT_EN
                    else if (cnt_q == 20'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = ERROR;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 20'd1;
                    end
`endif
                end
                HANDOFF: begin
                    state_d = ACTIVE;
                    idx_d   = idx_q + IDX_W'(1);
`ifdef MBINIT_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
                default: ;
            endcase
        end
    end

    // Sideband mux follows the step that will be active next cycle.
    always_comb begin
        sb_valid_d = 1'b0;
        sb_msg_d   = '0;
        if (state_d == ACTIVE) begin
            sb_valid_d = bus.i_substep_sb_valid[idx_d];
            if (sb_valid_d) sb_msg_d = bus.i_substep_sb_msg[int'(idx_d) * MSG_W +: MSG_W];
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            bus.o_substep_start_en <= '0;
            bus.o_TX_SbMessage     <= '0;
            bus.o_ValidOutDatat    <= 1'b0;
            bus.o_active_step      <= '0;
            bus.o_MBINIT_end       <= 1'b0;
            bus.o_train_error_req  <= 1'b0;
            bus.o_timeout          <= 1'b0;
        end else begin
            bus.o_substep_start_en <= (state_d == ACTIVE) ? (N_STEPS'(1) << idx_d) : '0;
            bus.o_TX_SbMessage     <= sb_msg_d;
            bus.o_ValidOutDatat    <= sb_valid_d;
            bus.o_active_step      <= idx_d;
            bus.o_MBINIT_end       <= (state_d == DONE);
            bus.o_train_error_req  <= (state_d == ERROR);
            bus.o_timeout          <= timeout_d;
        end
    end
endmodule

// File: tb/tb_mbinit_substep_sequencer.sv
// Table-driven bench for mbinit_substep_sequencer with a 1-cycle-latency expectation queue.
module tb_mbinit_substep_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mbinit_substep_sequencer_if #(.N_STEPS(6), .MSG_W(4)) bus ();

    mbinit_substep_sequencer #(
        .N_STEPS(6),
        .MSG_W(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [5:0] start;
        logic [3:0] msg;
        logic       vld;
        logic [2:0] step;
        logic       done;
        logic       err;
        logic       to;
    } out_t;

    typedef struct {
        string       name;
        logic        en;
        logic [5:0]  endv;
        logic [5:0]  errv;
        logic [5:0]  sbv;
        logic [23:0] sbm;
        out_t        exp;
    } vec_t;

    vec_t  vecs[$];
    out_t  exp_q[$];
    string name_q[$];
    int    passed = 0;
    int    total  = 0;

    function automatic out_t o(logic [5:0] s, logic [3:0] m, logic v, logic [2:0] st,
                               logic d, logic e, logic t);
        out_t r;
        r.start = s; r.msg = m; r.vld = v; r.step = st; r.done = d; r.err = e; r.to = t;
        return r;
    endfunction

    function automatic out_t f_idle();        return o(6'd0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0); endfunction
    function automatic out_t f_act(int i);    return o(6'(1 << i), 4'd0, 1'b0, 3'(i), 1'b0, 1'b0, 1'b0); endfunction
    function automatic out_t f_hand(int i);   return o(6'd0, 4'd0, 1'b0, 3'(i), 1'b0, 1'b0, 1'b0); endfunction
    function automatic out_t f_done();        return o(6'd0, 4'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0); endfunction
    function automatic out_t f_err(int i, logic t); return o(6'd0, 4'd0, 1'b0, 3'(i), 1'b0, 1'b1, t); endfunction

    function automatic out_t sample();
        return o(bus.o_substep_start_en, bus.o_TX_SbMessage, bus.o_ValidOutDatat,
                 bus.o_active_step, bus.o_MBINIT_end, bus.o_train_error_req, bus.o_timeout);
    endfunction

    task automatic add(string n, logic en, logic [5:0] e_end, logic [5:0] e_err,
                       logic [5:0] sbv, logic [23:0] sbm, out_t ex);
        vec_t v;
        v.name = n; v.en = en; v.endv = e_end; v.errv = e_err; v.sbv = sbv; v.sbm = sbm; v.exp = ex;
        vecs.push_back(v);
    endtask

    // From IDLE: enter ACTIVE at idx 0 and hand off up to idx k.
    task automatic walk_to(int k);
        add("entry", 1'b1, '0, '0, '0, '0, f_act(0));
        for (int i = 0; i < k; i++) begin
            add("handoff", 1'b1, 6'(1 << i), '0, '0, '0, f_hand(i));
            add("next_step", 1'b1, '0, '0, '0, '0, f_act(i + 1));
        end
    endtask

    task automatic check(string n, out_t ex);
        out_t a;
        a = sample();
        total++;
        if (a === ex) passed++;
        else $display("FAIL %s: actual=%h required=%h (start/msg/vld/step/done/err/to)", n, a, ex);
    endtask

    task automatic drive(logic en, logic [5:0] e_end, logic [5:0] e_err, logic [5:0] sbv, logic [23:0] sbm);
        bus.i_MBINIT_en        = en;
        bus.i_substep_end      = e_end;
        bus.i_substep_error    = e_err;
        bus.i_substep_sb_valid = sbv;
        bus.i_substep_sb_msg   = sbm;
    endtask

    initial begin
        logic [5:0] m;
        out_t ex;
        string n;

        // Happy path with ignored end/error noise from other steps.
        walk_to(0);
        for (int i = 0; i < 6; i++) begin
            m = 6'(1 << i);
            add("happy_wait", 1'b1, ~m, '0, '0, '0, f_act(i));
            add("happy_wait_noise", 1'b1, ~m, ~m, '0, '0, f_act(i));
            if (i < 5) begin
                add("happy_handoff", 1'b1, m, '0, '0, '0, f_hand(i));
                add("happy_next", 1'b1, '0, '0, '0, '0, f_act(i + 1));
            end else begin
                add("happy_done", 1'b1, m, '0, '0, '0, f_done());
            end
        end
        add("done_hold", 1'b1, '1, '1, '1, '0, f_done());
        add("done_release", 1'b0, '0, '0, '0, '0, f_idle());

        // Error during idx 2.
        walk_to(2);
        add("error_mid", 1'b1, '0, 6'b000100, '0, '0, f_err(2, 1'b0));
        add("error_hold", 1'b1, '1, '0, '0, '0, f_err(2, 1'b0));
        add("error_release", 1'b0, '0, '0, '0, '0, f_idle());

        // End and error together: error wins.
        walk_to(1);
        add("simul_end_err", 1'b1, 6'b000010, 6'b000010, '0, '0, f_err(1, 1'b0));
        add("simul_release", 1'b0, '0, '0, '0, '0, f_idle());

        // Abort beats a concurrent end; re-enable restarts at PARAM.
        walk_to(3);
        add("abort", 1'b0, 6'b001000, '0, '0, '0, f_idle());
        add("restart", 1'b1, '0, '0, '0, '0, f_act(0));
        add("restart_release", 1'b0, '0, '0, '0, '0, f_idle());

        // Sideband mux.
        add("mux_step0", 1'b1, '0, '0, 6'b010001, 24'h050001, o(6'd1, 4'b0001, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0));
        add("mux_step4_dropped", 1'b1, '0, '0, 6'b010000, 24'h050001, f_act(0));
        add("mux_no_valid", 1'b1, '0, '0, 6'b000000, 24'h00000f, f_act(0));
        add("mux_handoff", 1'b1, 6'b000001, '0, 6'b000011, 24'h000061, f_hand(0));
        add("mux_step1", 1'b1, '0, '0, 6'b000010, 24'h000060, o(6'd2, 4'b0110, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0));
        add("mux_release", 1'b0, '0, '0, 6'b000010, 24'h000060, f_idle());

        // Timeout at TIMEOUT_CYCLES=16 (only when the feature is built in).
        walk_to(0);
        for (int k = 1; k <= 17; k++) begin
`ifdef MBINIT_TIMEOUT_EN
            ex = (k < 16) ? f_act(0) : f_err(0, k == 16);
`else
            ex = f_act(0);
`endif
            add("timeout_wait", 1'b1, '0, '0, '0, '0, ex);
        end
        add("timeout_release", 1'b0, '0, '0, '0, '0, f_idle());

        // Reset state, with enable already high.
        drive(1'b1, '1, '0, '1, '1);
        repeat (2) @(posedge clk);
        #1 check("reset_state", f_idle());
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        @(posedge clk);
        #1 check("idle_after_reset", f_idle());

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].endv, vecs[i].errv, vecs[i].sbv, vecs[i].sbm);
            exp_q.push_back(vecs[i].exp);
            name_q.push_back(vecs[i].name);
            @(posedge clk);
            #1;
            ex = exp_q.pop_front();
            n  = name_q.pop_front();
            check(n, ex);
        end

        // Synchronous reset in the middle of a step.
        @(negedge clk);
        drive(1'b1, '0, '0, '0, '0);
        @(posedge clk);
        #1 check("pre_midreset", f_act(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check("midreset", f_idle());
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("after_midreset", f_act(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
